enc8to3_pend: RTL and testbench



---
 rtl/enc8to3_pend_pkg.sv | 12 +
 rtl/enc8to3_pend_prio.sv | 28 ++
 rtl/enc8to3_pend.sv | 101 ++++++++++
 tb/tb_enc8to3_pend.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/enc8to3_pend_pkg.sv
// rtl/enc8to3_pend_pkg.sv - shared constants and state type for the pending-request encoder
package enc_pkg;

  localparam int N_REQ = 8;
  localparam int IDX_W = 3;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_HOLD = 1'b1
  } state_t;

endpackage

// File: rtl/enc8to3_pend_prio.sv
// rtl/enc8to3_pend_prio.sv - rotating-start priority search over a request vector
// Search order is base-1, base-2, ... wrapping, base last; base=0 gives highest-index-first.
module enc_prio
  import enc_pkg::*;
#(
  parameter int N = N_REQ,
  parameter int W = $clog2(N)
) (
  input  logic [N-1:0] vec,
  input  logic [W-1:0] base,
  output logic [W-1:0] idx,
  output logic         any
);

  logic [W-1:0] w_pos;

  // Walk from lowest to highest precedence so the last hit is the winner.
  always_comb begin
    idx   = '0;
    w_pos = '0;
    any   = |vec;
    for (int i = 0; i < N; i++) begin
      w_pos = base + W'(i);
      if (vec[w_pos]) idx = w_pos;
    end
  end

endmodule

// File: rtl/enc8to3_pend.sv
// rtl/enc8to3_pend.sv - pending-request 8-to-3 encoder serving one index per valid/ready handshake
// Define ENC_ROUND_ROBIN_EN for rotating priority; default is fixed highest-index priority.
module enc8to3_pend
  import enc_pkg::*;
#(
  parameter int N = N_REQ,
  localparam int W = $clog2(N)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic [N-1:0] in,
  output logic [W-1:0] out,
  output logic         out_vld,
  input  logic         out_rdy,
  output logic [N-1:0] pend,
  output logic         dup
);

  state_t       r_state;
  logic [W-1:0] r_out;
  logic [N-1:0] r_pend;
  logic         r_dup;

  logic [N-1:0] w_req;
  logic [N-1:0] w_cand;
  logic [W-1:0] w_sel;
  logic         w_any;
  logic [W-1:0] w_base;
  logic [N-1:0] w_sel_mask;

  assign w_req      = en ? in : '0;
  assign w_cand     = r_pend | w_req;
  assign w_sel_mask = N'(1) << w_sel;

  enc_prio #(.N(N), .W(W)) u_prio (
    .vec  (w_cand),
    .base (w_base),
    .idx  (w_sel),
    .any  (w_any)
  );

`ifdef ENC_ROUND_ROBIN_EN
  logic [W-1:0] r_last;

  // The pointer follows every index loaded onto out.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_last <= '0;
    end else if (w_any && (r_state == ST_IDLE || out_rdy)) begin
      r_last <= w_sel;
    end
  end

  assign w_base = r_last;
`else
  assign w_base = '0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_out   <= '0;
      r_pend  <= '0;
      r_dup   <= 1'b0;
    end else begin
      r_dup <= |(w_req & r_pend);
      case (r_state)
        ST_IDLE: begin
          if (w_any) begin
            r_out   <= w_sel;
            r_pend  <= w_cand & ~w_sel_mask;
            r_state <= ST_HOLD;
          end else begin
            r_pend  <= w_cand;
          end
        end
        ST_HOLD: begin
          if (!out_rdy) begin
            r_pend <= w_cand;
          end else if (w_any) begin
            r_out  <= w_sel;
            r_pend <= w_cand & ~w_sel_mask;
          end else begin
            r_pend  <= w_cand;
            r_state <= ST_IDLE;
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign out     = r_out;
  assign out_vld = (r_state == ST_HOLD);
  assign pend    = r_pend;
  assign dup     = r_dup;

endmodule

// File: tb/tb_enc8to3_pend.sv
// tb/tb_enc8to3_pend.sv - randomized and directed checks of enc8to3_pend against a set-based model
module tb_enc8to3_pend;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en = 1'b0;
  logic [7:0] in = 8'h00;
  logic       out_rdy = 1'b0;
  logic [2:0] out;
  logic       out_vld;
  logic [7:0] pend;
  logic       dup;

  int n_vec = 0;
  int n_err = 0;

  logic [7:0] m_pend;
  logic [2:0] m_out;
  logic       m_vld;
  logic       m_dup;
  logic [2:0] m_last;

  enc8to3_pend dut (
    .clk     (clk),
    .rst     (rst),
    .en      (en),
    .in      (in),
    .out     (out),
    .out_vld (out_vld),
    .out_rdy (out_rdy),
    .pend    (pend),
    .dup     (dup)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // First set bit in the order last-1, last-2, ... (mod 8), with last itself tried at the end.
  function automatic logic [2:0] pick(input logic [7:0] cand, input logic [2:0] last);
    int order[$];
    for (int k = 1; k <= 8; k++) order.push_back((int'(last) - k + 8) % 8);
    foreach (order[q]) if (cand[order[q]]) return 3'(order[q]);
    return 3'd0;
  endfunction

  task automatic model_reset();
    m_pend = 8'h00;
    m_out  = 3'd0;
    m_vld  = 1'b0;
    m_dup  = 1'b0;
    m_last = 3'd0;
  endtask

  task automatic model_step(input logic e, input logic [7:0] i, input logic r);
    logic [7:0] req;
    logic [7:0] cand;
    logic [2:0] s;
    req   = e ? i : 8'h00;
    cand  = m_pend | req;
    m_dup = |(req & m_pend);
    if (m_vld && !r) begin
      m_pend = cand;
    end else if (cand != 8'h00) begin
      s      = pick(cand, m_last);
      m_out  = s;
      m_vld  = 1'b1;
      m_pend = cand & ~(8'h01 << s);
`ifdef ENC_ROUND_ROBIN_EN
      m_last = s;
`endif
    end else begin
      m_vld  = 1'b0;
      m_pend = cand;
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".out"}, 32'(out), 32'(m_out));
    chk({tag, ".vld"}, 32'(out_vld), 32'(m_vld));
    chk({tag, ".pend"}, 32'(pend), 32'(m_pend));
    chk({tag, ".dup"}, 32'(dup), 32'(m_dup));
  endtask

  task automatic step(input string tag, input logic e, input logic [7:0] i, input logic r);
    en = e;
    in = i;
    out_rdy = r;
    @(posedge clk);
    model_step(e, i, r);
    #1;
    check_all(tag);
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst = 1'b1;
    en = 1'b0;
    in = 8'h00;
    out_rdy = 1'b0;
    model_reset();
    #1;
    check_all("reset");
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    logic [2:0] seq[$];
    model_reset();
    #2;
    check_all("por");
    @(negedge clk);
    rst = 1'b0;

    // Reset between edges while holding out=7 with pend=0F.
    step("mid_load", 1'b1, 8'h8F, 1'b0);
    chk("mid_pend", 32'(pend), 32'h0F);
    @(negedge clk);
    rst = 1'b1;
    model_reset();
    #1;
    check_all("mid_rst");
    rst = 1'b0;
    step("mid_after", 1'b0, 8'h00, 1'b1);

    // Single event on an idle block.
    step("single", 1'b1, 8'h20, 1'b1);
    chk("single_out", 32'(out), 32'd5);
    step("single_end", 1'b1, 8'h00, 1'b1);
    chk("single_vld", 32'(out_vld), 32'd0);

    // Multi-hot burst drains 7,2,0 after reset in both priority modes.
    apply_reset();
    step("multi", 1'b1, 8'h85, 1'b1);
    seq.push_back(out);
    step("multi", 1'b1, 8'h00, 1'b1);
    seq.push_back(out);
    step("multi", 1'b1, 8'h00, 1'b1);
    seq.push_back(out);
    chk("multi_seq", {8'h0, 5'h0, seq[0], 5'h0, seq[1], 5'h0, seq[2]}, 32'h00070200);
    step("multi_end", 1'b1, 8'h00, 1'b1);
    chk("multi_vld", 32'(out_vld), 32'd0);

    // Backpressure holds out=7 with bit 0 pending.
    step("bp", 1'b1, 8'h81, 1'b0);
    for (int k = 0; k < 3; k++) step("bp_hold", 1'b1, 8'h00, 1'b0);
    chk("bp_out", 32'(out), 32'd7);
    chk("bp_pend", 32'(pend), 32'h01);

    // Duplicate on a pending bit, then gated capture.
    step("dup_hit", 1'b1, 8'h01, 1'b0);
    chk("dup_pulse", 32'(dup), 32'd1);
    step("dup_clear", 1'b1, 8'h00, 1'b0);
    chk("dup_once", 32'(dup), 32'd0);
    step("gated", 1'b0, 8'hFF, 1'b0);
    chk("gated_pend", 32'(pend), 32'h01);
    step("bp_go", 1'b1, 8'h00, 1'b1);
    chk("bp_next", 32'(out), 32'd0);
    step("bp_idle", 1'b1, 8'h00, 1'b1);

    // Random traffic against the model.
    for (int k = 0; k < 400; k++) begin
      logic [7:0] r_in;
      r_in = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'h00;
      step("rand", ($urandom_range(0, 4) != 0), r_in, ($urandom_range(0, 2) != 0));
      if (k % 97 == 96) apply_reset();
    end

    // Loop-back: re-expanding out must reproduce the single-bit request.
    apply_reset();
    for (int k = 0; k < 8; k++) begin
      logic [7:0] onehot;
      onehot = 8'h01 << k;
      step("loop", 1'b1, onehot, 1'b1);
      chk("loop_dec", 32'(8'h01 << out), 32'(onehot));
      step("loop_idle", 1'b1, 8'h00, 1'b1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
